id_ex_stage: RTL and testbench

- Pipeline register between the register-file read (decode) stage and execute.
- Captures both register-file read ports, the immediate, destination address and the control bundle each cycle.
- Detects load-use hazards against the instruction currently in EX, requests a one-cycle upstream stall and inserts a bubble.
- Honours downstream hold and branch flush.

---
 rtl/id_ex_stage_pkg.sv | 24 ++
 rtl/id_ex_stage_if.sv | 50 +++++
 rtl/id_ex_stage_hazard_detect.sv | 25 ++
 rtl/id_ex_stage.sv | 146 ++++++++++++++
 tb/tb_id_ex_stage.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: default widths,
// the bubble control value and the per-edge load selector.
package id_ex_stage_pkg;

   localparam int DEF_DWIDTH = 32;
   localparam int DEF_AWIDTH = 5;
   localparam int DEF_CWIDTH = 8;

   // Control bundle carried by a bubble; EX treats all-zero control as a no-op.
   localparam logic [DEF_CWIDTH-1:0] CTRL_BUBBLE = '0;

   typedef enum logic [1:0] {
      SEL_LOAD   = 2'd0,
      SEL_HOLD   = 2'd1,
      SEL_BUBBLE = 2'd2
   } ex_sel_e;

   // Register address compare where r0 never matches anything.
   function automatic logic reg_match(input logic [DEF_AWIDTH-1:0] a,
                                      input logic [DEF_AWIDTH-1:0] b);
      return (a != '0) && (a == b);
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs and EX-side outputs of the ID/EX stage.
// master: decode/control/write-back driver; slave: the pipeline register.
interface id_ex_stage_if
   import id_ex_stage_pkg::*;
#(
   parameter int DWIDTH = DEF_DWIDTH,
   parameter int AWIDTH = DEF_AWIDTH,
   parameter int CWIDTH = DEF_CWIDTH
);
   logic              id_valid;
   logic [AWIDTH-1:0] id_rs_addr;
   logic [AWIDTH-1:0] id_rt_addr;
   logic [AWIDTH-1:0] id_rd_addr;
   logic [DWIDTH-1:0] id_rs_data;
   logic [DWIDTH-1:0] id_rt_data;
   logic [DWIDTH-1:0] id_imm;
   logic [CWIDTH-1:0] id_ctrl;
   logic              id_mem_read;
   logic              ext_stall;
   logic              flush;
   logic              wb_wr_en;
   logic [AWIDTH-1:0] wb_addr;
   logic [DWIDTH-1:0] wb_data;

   logic              ex_valid;
   logic [AWIDTH-1:0] ex_rs_addr;
   logic [AWIDTH-1:0] ex_rt_addr;
   logic [AWIDTH-1:0] ex_rd_addr;
   logic [DWIDTH-1:0] ex_rs_data;
   logic [DWIDTH-1:0] ex_rt_data;
   logic [DWIDTH-1:0] ex_imm;
   logic [CWIDTH-1:0] ex_ctrl;
   logic              ex_mem_read;
   logic              stall_out;

   modport master (
      output id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
             id_imm, id_ctrl, id_mem_read, ext_stall, flush, wb_wr_en, wb_addr, wb_data,
      input  ex_valid, ex_rs_addr, ex_rt_addr, ex_rd_addr, ex_rs_data, ex_rt_data,
             ex_imm, ex_ctrl, ex_mem_read, stall_out
   );

   modport slave (
      input  id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
             id_imm, id_ctrl, id_mem_read, ext_stall, flush, wb_wr_en, wb_addr, wb_data,
      output ex_valid, ex_rs_addr, ex_rt_addr, ex_rd_addr, ex_rs_data, ex_rt_data,
             ex_imm, ex_ctrl, ex_mem_read, stall_out
   );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detector: the load sitting in EX writes a
// register that the instruction in decode wants to read.
module hazard_detect #(
   parameter int AWIDTH = 5
) (
   input  logic              id_valid,
   input  logic [AWIDTH-1:0] id_rs_addr,
   input  logic [AWIDTH-1:0] id_rt_addr,
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic [AWIDTH-1:0] ex_rt_addr,
   output logic              hazard
);

   logic rs_hit;
   logic rt_hit;

   always_comb begin
      rs_hit = (ex_rt_addr == id_rs_addr);
      rt_hit = (ex_rt_addr == id_rt_addr);
      // A load into r0 produces nothing, so it can never cause a stall.
      hazard = id_valid & ex_valid & ex_mem_read & (ex_rt_addr != '0) & (rs_hit | rt_hit);
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, hold and flush.
// Optional WB_BYPASS_EN: write-back data bypasses the register-file operands.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int DWIDTH = DEF_DWIDTH,
   parameter int AWIDTH = DEF_AWIDTH,
   parameter int CWIDTH = DEF_CWIDTH
) (
   input logic          r_clk,
   input logic          r_rst,
   id_ex_stage_if.slave bus
);

   localparam logic [CWIDTH-1:0] BUBBLE_CTRL = CWIDTH'(CTRL_BUBBLE);

   logic              hazard;
   ex_sel_e           sel;
   logic [DWIDTH-1:0] rs_src;
   logic [DWIDTH-1:0] rt_src;

   logic              ex_valid_d,    ex_valid_q;
   logic [AWIDTH-1:0] ex_rs_addr_d,  ex_rs_addr_q;
   logic [AWIDTH-1:0] ex_rt_addr_d,  ex_rt_addr_q;
   logic [AWIDTH-1:0] ex_rd_addr_d,  ex_rd_addr_q;
   logic [DWIDTH-1:0] ex_rs_data_d,  ex_rs_data_q;
   logic [DWIDTH-1:0] ex_rt_data_d,  ex_rt_data_q;
   logic [DWIDTH-1:0] ex_imm_d,      ex_imm_q;
   logic [CWIDTH-1:0] ex_ctrl_d,     ex_ctrl_q;
   logic              ex_mem_read_d, ex_mem_read_q;

   hazard_detect #(.AWIDTH(AWIDTH)) u_hazard (
      .id_valid    (bus.id_valid),
      .id_rs_addr  (bus.id_rs_addr),
      .id_rt_addr  (bus.id_rt_addr),
      .ex_valid    (ex_valid_q),
      .ex_mem_read (ex_mem_read_q),
      .ex_rt_addr  (ex_rt_addr_q),
      .hazard      (hazard)
   );

`ifdef WB_BYPASS_EN
   logic byp_rs;
   logic byp_rt;

   always_comb begin
      byp_rs = bus.wb_wr_en & (bus.wb_addr != '0) & (bus.wb_addr == bus.id_rs_addr);
      byp_rt = bus.wb_wr_en & (bus.wb_addr != '0) & (bus.wb_addr == bus.id_rt_addr);
      rs_src = byp_rs ? bus.wb_data : bus.id_rs_data;
      rt_src = byp_rt ? bus.wb_data : bus.id_rt_data;
   end
`else
   always_comb begin
      rs_src = bus.id_rs_data;
      rt_src = bus.id_rt_data;
   end
`endif

   // Flush beats hold, and hold beats the load-use bubble.
   always_comb begin
      sel = SEL_LOAD;
      if (bus.flush) begin
         sel = SEL_BUBBLE;
      end else if (bus.ext_stall) begin
         sel = SEL_HOLD;
      end else if (hazard) begin
         sel = SEL_BUBBLE;
      end
   end

   always_comb begin
      ex_valid_d    = ex_valid_q;
      ex_rs_addr_d  = ex_rs_addr_q;
      ex_rt_addr_d  = ex_rt_addr_q;
      ex_rd_addr_d  = ex_rd_addr_q;
      ex_rs_data_d  = ex_rs_data_q;
      ex_rt_data_d  = ex_rt_data_q;
      ex_imm_d      = ex_imm_q;
      ex_ctrl_d     = ex_ctrl_q;
      ex_mem_read_d = ex_mem_read_q;
      case (sel)
         SEL_LOAD: begin
            ex_valid_d    = bus.id_valid;
            ex_rs_addr_d  = bus.id_rs_addr;
            ex_rt_addr_d  = bus.id_rt_addr;
            ex_rd_addr_d  = bus.id_rd_addr;
            ex_rs_data_d  = rs_src;
            ex_rt_data_d  = rt_src;
            ex_imm_d      = bus.id_imm;
            ex_ctrl_d     = bus.id_ctrl;
            ex_mem_read_d = bus.id_mem_read;
         end
         SEL_BUBBLE: begin
            // Clearing mem_read is what lets a load-use stall release after one cycle.
            ex_valid_d    = 1'b0;
            ex_rs_addr_d  = '0;
            ex_rt_addr_d  = '0;
            ex_rd_addr_d  = '0;
            ex_rs_data_d  = '0;
            ex_rt_data_d  = '0;
            ex_imm_d      = '0;
            ex_ctrl_d     = BUBBLE_CTRL;
            ex_mem_read_d = 1'b0;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge r_clk or posedge r_rst) begin
      if (r_rst) begin
         ex_valid_q    <= 1'b0;
         ex_rs_addr_q  <= '0;
         ex_rt_addr_q  <= '0;
         ex_rd_addr_q  <= '0;
         ex_rs_data_q  <= '0;
         ex_rt_data_q  <= '0;
         ex_imm_q      <= '0;
         ex_ctrl_q     <= '0;
         ex_mem_read_q <= 1'b0;
      end else begin
         ex_valid_q    <= ex_valid_d;
         ex_rs_addr_q  <= ex_rs_addr_d;
         ex_rt_addr_q  <= ex_rt_addr_d;
         ex_rd_addr_q  <= ex_rd_addr_d;
         ex_rs_data_q  <= ex_rs_data_d;
         ex_rt_data_q  <= ex_rt_data_d;
         ex_imm_q      <= ex_imm_d;
         ex_ctrl_q     <= ex_ctrl_d;
         ex_mem_read_q <= ex_mem_read_d;
      end
   end

   // Reset clears ex_valid asynchronously, so stall_out drops with it.
   assign bus.stall_out   = hazard & ~bus.flush & ~bus.ext_stall;
   assign bus.ex_valid    = ex_valid_q;
   assign bus.ex_rs_addr  = ex_rs_addr_q;
   assign bus.ex_rt_addr  = ex_rt_addr_q;
   assign bus.ex_rd_addr  = ex_rd_addr_q;
   assign bus.ex_rs_data  = ex_rs_data_q;
   assign bus.ex_rt_data  = ex_rt_data_q;
   assign bus.ex_imm      = ex_imm_q;
   assign bus.ex_ctrl     = ex_ctrl_q;
   assign bus.ex_mem_read = ex_mem_read_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push hand-computed
// expectations; a monitor pops and compares stall_out and the EX registers.
module tb_id_ex_stage;

   typedef struct packed {
      logic        v;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] rsd;
      logic [31:0] rtd;
      logic [31:0] imm;
      logic [7:0]  ctrl;
      logic        mr;
   } ex_t;

   typedef struct {
      logic stall;
      ex_t  ex;
   } exp_t;

   typedef struct {
      ex_t         id;
      logic        ext_stall;
      logic        flush;
      logic        wb_en;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data;
   } stim_t;

`ifdef WB_BYPASS_EN
   localparam logic [31:0] EXP_BYP_RS = 32'h0000_ABCD;
   localparam logic [31:0] EXP_BYP_RT = 32'h0000_ABCD;
`else
   localparam logic [31:0] EXP_BYP_RS = 32'h0000_0001;
   localparam logic [31:0] EXP_BYP_RT = 32'h0000_0006;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t q[$];

   id_ex_stage_if bus_if ();

   id_ex_stage dut (
      .r_clk (clk),
      .r_rst (rst),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ex_t f(logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                             logic [31:0] rsd, logic [31:0] rtd, logic [31:0] imm,
                             logic [7:0] ctrl, logic mr);
      ex_t r;
      r.v = v; r.rs = rs; r.rt = rt; r.rd = rd;
      r.rsd = rsd; r.rtd = rtd; r.imm = imm; r.ctrl = ctrl; r.mr = mr;
      return r;
   endfunction

   function automatic stim_t st(ex_t id, logic es, logic fl, logic wen,
                                logic [4:0] wa, logic [31:0] wd);
      stim_t s;
      s.id = id; s.ext_stall = es; s.flush = fl;
      s.wb_en = wen; s.wb_addr = wa; s.wb_data = wd;
      return s;
   endfunction

   function automatic ex_t ex_actual();
      return {bus_if.ex_valid, bus_if.ex_rs_addr, bus_if.ex_rt_addr, bus_if.ex_rd_addr,
              bus_if.ex_rs_data, bus_if.ex_rt_data, bus_if.ex_imm, bus_if.ex_ctrl,
              bus_if.ex_mem_read};
   endfunction

   task automatic check_ex(input string name, input ex_t act, input ex_t req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b required %b", name, act, req);
      end
   endtask

   task automatic drive(input stim_t s);
      bus_if.id_valid    = s.id.v;
      bus_if.id_rs_addr  = s.id.rs;
      bus_if.id_rt_addr  = s.id.rt;
      bus_if.id_rd_addr  = s.id.rd;
      bus_if.id_rs_data  = s.id.rsd;
      bus_if.id_rt_data  = s.id.rtd;
      bus_if.id_imm      = s.id.imm;
      bus_if.id_ctrl     = s.id.ctrl;
      bus_if.id_mem_read = s.id.mr;
      bus_if.ext_stall   = s.ext_stall;
      bus_if.flush       = s.flush;
      bus_if.wb_wr_en    = s.wb_en;
      bus_if.wb_addr     = s.wb_addr;
      bus_if.wb_data     = s.wb_data;
   endtask

   task automatic apply_push(input stim_t s, input logic exp_stall, input ex_t exp_ex);
      exp_t e;
      drive(s);
      e.stall = exp_stall;
      e.ex    = exp_ex;
      q.push_back(e);
   endtask

   task automatic step(input stim_t s, input logic exp_stall, input ex_t exp_ex);
      @(negedge clk);
      apply_push(s, exp_stall, exp_ex);
   endtask

   // Monitor: stall_out is checked mid low phase, the EX registers just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() != 0) begin
            e = q.pop_front();
            check_bit("stall_out", bus_if.stall_out, e.stall);
            @(posedge clk);
            #1;
            check_ex("ex_regs", ex_actual(), e.ex);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      ex_t z;
      ex_t ld9, ld_a, hz;
      stim_t s_hz;
      checks = 0;
      errors = 0;
      z = '0;
      rst = 1'b1;
      drive(st(z, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0));
      #1;
      check_ex("reset_state", ex_actual(), z);
      check_bit("reset_stall", bus_if.stall_out, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Plain load, then a load into EX followed by a load-use in decode.
      step(st(f(1,3,4,5,32'h11,32'h22,32'h100,8'h5A,0), 0,0,0,0,0), 1'b0,
           f(1,3,4,5,32'h11,32'h22,32'h100,8'h5A,0));
      step(st(f(1,1,7,7,32'hA,32'hB,32'h4,8'h21,1), 0,0,0,0,0), 1'b0,
           f(1,1,7,7,32'hA,32'hB,32'h4,8'h21,1));
      step(st(f(1,7,2,8,32'h77,32'h2,32'h8,8'h33,0), 0,0,0,0,0), 1'b1, z);
      step(st(f(1,7,2,8,32'h77,32'h2,32'h8,8'h33,0), 0,0,0,0,0), 1'b0,
           f(1,7,2,8,32'h77,32'h2,32'h8,8'h33,0));

      // Load to r0 then decode reading r0: no stall.
      step(st(f(1,1,0,0,32'h1,32'h0,32'h0,8'h44,1), 0,0,0,0,0), 1'b0,
           f(1,1,0,0,32'h1,32'h0,32'h0,8'h44,1));
      step(st(f(1,0,0,9,32'h5,32'h6,32'h10,8'h55,0), 0,0,0,0,0), 1'b0,
           f(1,0,0,9,32'h5,32'h6,32'h10,8'h55,0));

      // Flush with hold and hazard all present: bubble, no stall.
      step(st(f(1,2,7,7,32'h20,32'h70,32'hC,8'h66,1), 0,0,0,0,0), 1'b0,
           f(1,2,7,7,32'h20,32'h70,32'hC,8'h66,1));
      step(st(f(1,7,3,4,32'h99,32'h3,32'h0,8'h77,0), 1,1,0,0,0), 1'b0, z);

      // Hold for three cycles with a hazard pending, then the stall fires.
      ld9 = f(1,3,4,6,32'h31,32'h41,32'h1234,8'h88,1);
      step(st(ld9, 0,0,0,0,0), 1'b0, ld9);
      for (int i = 0; i < 3; i++)
         step(st(f(1,4,5,10,32'hDD,32'hEE,32'h2,8'h99,0), 1,0,0,0,0), 1'b0, ld9);
      step(st(f(1,4,5,10,32'hDD,32'hEE,32'h2,8'h99,0), 0,0,0,0,0), 1'b1, z);
      step(st(f(1,4,5,10,32'hDD,32'hEE,32'h2,8'h99,0), 0,0,0,0,0), 1'b0,
           f(1,4,5,10,32'hDD,32'hEE,32'h2,8'h99,0));

      // Invalid decode slot: fields latched, valid low.
      step(st(f(0,11,12,13,32'h3,32'h4,32'h0,8'h11,0), 0,0,0,0,0), 1'b0,
           f(0,11,12,13,32'h3,32'h4,32'h0,8'h11,0));

      // Write-back bypass on rs, suppressed for r0, then on rt.
      step(st(f(1,9,6,2,32'h1,32'h66,32'h0,8'h12,0), 0,0,1,5'd9,32'hABCD), 1'b0,
           f(1,9,6,2,EXP_BYP_RS,32'h66,32'h0,8'h12,0));
      step(st(f(1,0,0,3,32'h1,32'h2,32'h0,8'h13,0), 0,0,1,5'd0,32'hABCD), 1'b0,
           f(1,0,0,3,32'h1,32'h2,32'h0,8'h13,0));
      step(st(f(1,1,9,4,32'h5,32'h6,32'h0,8'h14,0), 0,0,1,5'd9,32'hABCD), 1'b0,
           f(1,1,9,4,32'h5,EXP_BYP_RT,32'h0,8'h14,0));
      repeat (3) @(negedge clk);

      // Asynchronous reset in the high phase with a valid EX slot.
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_ex("async_reset", ex_actual(), z);
      check_bit("async_reset_stall", bus_if.stall_out, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Reset during a load-use stall, then the first edge loads decode.
      ld_a = f(1,1,7,7,32'hA1,32'hB1,32'h4,8'h21,1);
      step(st(ld_a, 0,0,0,0,0), 1'b0, ld_a);
      @(posedge clk);
      #1;
      hz = f(1,7,2,8,32'h77,32'h2,32'h8,8'h33,0);
      s_hz = st(hz, 0,0,0,0,0);
      @(negedge clk);
      drive(s_hz);
      #2;
      check_bit("stall_before_reset", bus_if.stall_out, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      check_bit("stall_in_reset", bus_if.stall_out, 1'b0);
      check_ex("ex_in_reset", ex_actual(), z);
      @(negedge clk);
      rst = 1'b0;
      apply_push(s_hz, 1'b0, hz);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
